ws2812_drv: RTL and testbench
=============================

Name: ws2812_drv

Overview:
- Serial line driver for the 8x8 WS2812 LED matrix. It sits directly downstream of data_cfg.
- It generates the cnt_bit/cnt_pixel addresses that data_cfg decodes, and consumes data_cfg's combinational bit output.
- It encodes that bit as the WS2812 NRZ pulse waveform on a single data pin.
- One frame is NUM_PIXEL x 24 bits, MSB-first per pixel (data_cfg indexes bit 23-cnt_bit). Each frame ends with a low latch period.

Parameters:
- NUM_PIXEL, 64, pixels per frame; cnt_pixel runs 0..NUM_PIXEL-1.
- T_BIT, 60, clock cycles per bit slot (1.2 us at 50 MHz).
- T0H, 15, high cycles for a 0 bit (0.3 us).
- T1H, 45, high cycles for a 1 bit (0.9 us).
- T_RST, 15000, low cycles for latch/reset (300 us).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  level request to send a frame; if held high, frames run back-to-back.
- bit_in  in  1  pixel bit from data_cfg for the current cnt_pixel/cnt_bit.
- cnt_bit  out  5  bit index within pixel, 0..23; registered.
- cnt_pixel  out  7  pixel index, 0..NUM_PIXEL-1; registered.
- dout  out  1  WS2812 serial data line; registered.
- busy  out  1  high in DATA and LATCH states.
- frame_done  out  1  one-cycle pulse at the end of LATCH.

Behaviour:
- Reset (async, sys_rst_n=0): state=IDLE, cnt_cyc=0, cnt_bit=0, cnt_pixel=0, dout=0, busy=0, frame_done=0. Effective immediately, including mid-frame. dout must never glitch high during reset.
- States: IDLE, DATA, LATCH.
- IDLE:
  - dout=0, counters held at 0.
  - start=1 -> DATA on the next edge.
- DATA:
  - cnt_cyc counts 0..T_BIT-1.
  - At cnt_cyc=T_BIT-1: cnt_bit increments. At cnt_bit=23 it wraps to 0 and cnt_pixel increments.
  - At cnt_bit=23, cnt_pixel=NUM_PIXEL-1, cnt_cyc=T_BIT-1: go to LATCH, counters reset to 0.
- dout timing:
  - dout <= (cnt_cyc < (bit_in ? T1H : T0H)), evaluated in DATA only; otherwise dout <= 0.
  - dout therefore lags cnt_cyc by exactly one cycle, uniformly for every slot.
  - cnt_bit/cnt_pixel are stable for the whole slot, so bit_in (combinational from data_cfg) is stable when sampled.
- LATCH:
  - dout=0; cnt_cyc counts 0..T_RST-1.
  - At T_RST-1: frame_done=1 for one cycle. Next state is DATA if start=1 on that edge, else IDLE.
- start is ignored while busy. No abort except reset.
- busy=1 from the first DATA cycle through the last LATCH cycle inclusive.
- cnt_cyc width: clog2(max(T_BIT,T_RST)) bits (14 with defaults).
  - Compare widths are matched; no overflow is possible.
- Frame length: NUM_PIXEL*24*T_BIT + T_RST cycles. Defaults: 92160+15000 = 107160.
- Parameter legality, asserted in sim: 0 < T0H < T1H < T_BIT; NUM_PIXEL <= 128.

Decomposition:
- Shared package ws2812_pkg:
  - state enum (IDLE/DATA/LATCH)
  - BITS_PER_PIXEL=24
  - default timing constants, shared with any future multi-panel driver
- One natural sub-module, ws2812_bit_enc: cnt_cyc counter plus high-time compare producing dout and a slot_end strobe.
- The pixel/bit counters and the FSM stay in ws2812_drv.

Test Plan:
All scenarios use T_BIT=6, T0H=2, T1H=4, T_RST=10, NUM_PIXEL=2 unless noted.
- Single frame, bit_in=0 constantly; start pulsed 1 cycle:
  - dout is 48 slots of pattern 110000.
  - dout then stays low for 10 cycles; frame_done pulses once.
  - busy is high for 2*24*6+10 = 298 cycles, then IDLE.
- bit_in = cnt_bit[0] (alternating):
  - Slot patterns alternate 110000 / 111100.
  - cnt_bit walks 0..23, 0..23 with cnt_pixel 0 then 1.
  - cnt_bit is 0 and cnt_pixel is 0 in LATCH.
- start held high:
  - DATA restarts the cycle after frame_done.
  - Second frame timing is identical to the first.
  - No extra idle cycle.
- start toggled during DATA and LATCH: no effect; exactly one frame is produced.
- Reset asserted mid-pixel 1, bit 10, while dout=1:
  - dout=0 asynchronously, all counters 0, state IDLE, busy=0.
  - After release with start=0, dout stays low.
- Default parameters, bit_in tied to 1:
  - Measured high time is 45 cycles and period is 60 cycles.
  - Total frame is 107160 cycles.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types and default timing for WS2812 serial line drivers.
// A future multi-panel driver is expected to reuse these constants.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  localparam int unsigned BITS_PER_PIXEL = 24;

  // Defaults assume a 50 MHz system clock.
  localparam int unsigned DEF_NUM_PIXEL = 64;
  localparam int unsigned DEF_T_BIT     = 60;
  localparam int unsigned DEF_T0H       = 15;
  localparam int unsigned DEF_T1H       = 45;
  localparam int unsigned DEF_T_RST     = 15000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_enc.sv
// Slot cycle counter and NRZ high-time compare for one WS2812 bit slot.
// The same counter times the latch period when latch_mode is set.
module ws2812_bit_enc
  import ws2812_pkg::*;
#(
  parameter int unsigned T_BIT = DEF_T_BIT,
  parameter int unsigned T0H   = DEF_T0H,
  parameter int unsigned T1H   = DEF_T1H,
  parameter int unsigned T_RST = DEF_T_RST
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic latch_mode,
  input  logic bit_in,
  output logic slot_end,
  output logic dout
);

  localparam int unsigned CYC_W = $clog2(max_u(T_BIT, T_RST));

  logic [CYC_W-1:0] cnt_cyc_q, cnt_cyc_d;
  logic [CYC_W-1:0] limit_s, hi_len_s;
  logic             slot_end_s;
  logic             dout_q, dout_d;

  // Next counter value and next line level.
  always_comb begin
    limit_s    = latch_mode ? CYC_W'(T_RST - 1) : CYC_W'(T_BIT - 1);
    hi_len_s   = bit_in ? CYC_W'(T1H) : CYC_W'(T0H);
    slot_end_s = run && (cnt_cyc_q == limit_s);
    if (!run) begin
      cnt_cyc_d = '0;
    end else if (slot_end_s) begin
      cnt_cyc_d = '0;
    end else begin
      cnt_cyc_d = cnt_cyc_q + CYC_W'(1);
    end
    // Registered compare: the line lags cnt_cyc by one cycle in every slot.
    dout_d = run && !latch_mode && (cnt_cyc_q < hi_len_s);
  end

  // Counter and line registers; reset forces the line low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_cyc_q <= '0;
      dout_q    <= 1'b0;
    end else begin
      cnt_cyc_q <= cnt_cyc_d;
      dout_q    <= dout_d;
    end
  end

  assign slot_end = slot_end_s;
  assign dout     = dout_q;

endmodule

// File: rtl/ws2812_drv_chk.sv
// Simulation-only legality check on the driver's timing parameters.
module ws2812_drv_chk
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_PIXEL = DEF_NUM_PIXEL,
  parameter int unsigned T_BIT     = DEF_T_BIT,
  parameter int unsigned T0H       = DEF_T0H,
  parameter int unsigned T1H       = DEF_T1H
) (
  input logic clk
);

  param_legal_a: assert property (@(posedge clk)
    (T0H > 0) && (T0H < T1H) && (T1H < T_BIT) && (NUM_PIXEL > 0) && (NUM_PIXEL <= 128));

endmodule

// File: rtl/ws2812_drv.sv
// WS2812 frame sequencer: walks pixel/bit addresses for data_cfg, drives the
// NRZ line through ws2812_bit_enc and closes each frame with a latch period.
module ws2812_drv
  import ws2812_pkg::*;
#(
  parameter int unsigned NUM_PIXEL = DEF_NUM_PIXEL,
  parameter int unsigned T_BIT     = DEF_T_BIT,
  parameter int unsigned T0H       = DEF_T0H,
  parameter int unsigned T1H       = DEF_T1H,
  parameter int unsigned T_RST     = DEF_T_RST
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic       bit_in,
  output logic [4:0] cnt_bit,
  output logic [6:0] cnt_pixel,
  output logic       dout,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [4:0] LAST_BIT   = 5'(BITS_PER_PIXEL - 1);
  localparam logic [6:0] LAST_PIXEL = 7'(NUM_PIXEL - 1);

  state_e     state_q, state_d;
  logic [4:0] cnt_bit_q, cnt_bit_d;
  logic [6:0] cnt_pixel_q, cnt_pixel_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;
  logic       slot_end_s;

  ws2812_bit_enc #(
    .T_BIT (T_BIT),
    .T0H   (T0H),
    .T1H   (T1H),
    .T_RST (T_RST)
  ) u_enc (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .run        (state_q != ST_IDLE),
    .latch_mode (state_q == ST_LATCH),
    .bit_in     (bit_in),
    .slot_end   (slot_end_s),
    .dout       (dout)
  );

  ws2812_drv_chk #(
    .NUM_PIXEL (NUM_PIXEL),
    .T_BIT     (T_BIT),
    .T0H       (T0H),
    .T1H       (T1H)
  ) u_chk (
    .clk (sys_clk)
  );

  // Frame sequencing; start is only looked at in IDLE and on the final latch cycle.
  always_comb begin
    state_d      = state_q;
    cnt_bit_d    = cnt_bit_q;
    cnt_pixel_d  = cnt_pixel_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_bit_d   = 5'd0;
        cnt_pixel_d = 7'd0;
        if (start) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (!slot_end_s) begin
          state_d = ST_DATA;
        end else if (cnt_bit_q != LAST_BIT) begin
          cnt_bit_d = cnt_bit_q + 5'd1;
        end else if (cnt_pixel_q != LAST_PIXEL) begin
          cnt_bit_d   = 5'd0;
          cnt_pixel_d = cnt_pixel_q + 7'd1;
        end else begin
          cnt_bit_d   = 5'd0;
          cnt_pixel_d = 7'd0;
          state_d     = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (slot_end_s) begin
          frame_done_d = 1'b1;
          state_d      = start ? ST_DATA : ST_IDLE;
        end else begin
          state_d = ST_LATCH;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_bit_d   = 5'd0;
        cnt_pixel_d = 7'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_bit_q    <= 5'd0;
      cnt_pixel_q  <= 7'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_bit_q    <= cnt_bit_d;
      cnt_pixel_q  <= cnt_pixel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign cnt_bit    = cnt_bit_q;
  assign cnt_pixel  = cnt_pixel_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_drv.sv
// Scoreboard bench for ws2812_drv with reduced timing (2 pixels, 6-cycle slots).
// A behavioural model turns pixel words into expected pulses; a monitor measures the line.
module tb_ws2812_drv;

  localparam int NP = 2;
  localparam int TB = 6;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int TR = 10;
  localparam int FRAME_LEN = NP * 24 * TB + TR;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       bit_in;
  logic [4:0] cnt_bit;
  logic [6:0] cnt_pixel;
  logic       dout;
  logic       busy;
  logic       frame_done;

  logic [23:0] pix [NP];
  logic [23:0] cur_pix;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int hi; int gap; int px; int bt;} pulse_t;
  typedef struct {int len; bit restart;} frame_t;
  pulse_t exp_p[$];
  frame_t exp_f[$];

  ws2812_drv #(
    .NUM_PIXEL (NP),
    .T_BIT     (TB),
    .T0H       (T0),
    .T1H       (T1),
    .T_RST     (TR)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .cnt_bit    (cnt_bit),
    .cnt_pixel  (cnt_pixel),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in for data_cfg: MSB-first bit of the addressed pixel word.
  always_comb begin
    cur_pix = pix[cnt_pixel[0]];
    bit_in  = cur_pix[5'd23 - cnt_bit];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Expected pulses: one per bit, high for T1 or T0 cycles, rises TB apart.
  task automatic push_frame(input bit chained, input bit restart);
    pulse_t e;
    frame_t f;
    for (int p = 0; p < NP; p++) begin
      for (int b = 0; b < 24; b++) begin
        e.hi  = pix[p][23 - b] ? T1 : T0;
        e.gap = (p == 0 && b == 0) ? (chained ? TB + TR : 0) : TB;
        e.px  = p;
        e.bt  = b;
        exp_p.push_back(e);
      end
    end
    f.len     = FRAME_LEN;
    f.restart = restart;
    exp_f.push_back(f);
  endtask

  task automatic wait_fd(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < FRAME_LEN + 50);
    check(nm, frame_done, 1);
  endtask

  task automatic run_single(input string nm);
    push_frame(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_fd(nm);
    repeat (8) @(negedge clk);
  endtask

  // Monitor state
  int   cyc = 0, rise_cyc = 0, last_rise = 0, gap_meas = 0, fstart = 0;
  int   r_px = 0, r_bt = 0;
  logic p_dout = 1'b0, p_busy = 1'b0;
  logic [4:0] p_cb = 5'd0;
  logic [6:0] p_cp = 7'd0;
  bit   have_rise = 1'b0;

  initial begin
    pulse_t e;
    frame_t f;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        p_dout = 1'b0; p_busy = 1'b0; have_rise = 1'b0; p_cb = 5'd0; p_cp = 7'd0;
      end else begin
        if (dout === 1'b1 && p_dout !== 1'b1) begin
          gap_meas = cyc - last_rise; last_rise = cyc; rise_cyc = cyc;
          r_px = int'(cnt_pixel); r_bt = int'(cnt_bit); have_rise = 1'b1;
        end
        if (dout === 1'b0 && p_dout === 1'b1 && have_rise) begin
          have_rise = 1'b0;
          if (exp_p.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", rise_cyc);
          end else begin
            e = exp_p.pop_front();
            check("pulse_high", cyc - rise_cyc, e.hi);
            check("pulse_pixel", r_px, e.px);
            check("pulse_bit", r_bt, e.bt);
            if (e.gap != 0) check("slot_period", gap_meas, e.gap);
          end
        end
        if (busy === 1'b1 && p_busy !== 1'b1) fstart = cyc;
        if (frame_done === 1'b1) begin
          if (exp_f.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_frame_done: got pulse at cycle %0d, expected none", cyc);
          end else begin
            f = exp_f.pop_front();
            check("frame_len", cyc - fstart, f.len);
            check("restart_busy", busy, f.restart);
            check("latch_counters", {p_cp, p_cb}, 0);
          end
          fstart = cyc;
        end
        p_dout = dout; p_busy = busy; p_cb = cnt_bit; p_cp = cnt_pixel;
      end
    end
  end

  initial begin
    bit found;
    bit stayed_low;
    rst_n = 1'b0;
    start = 1'b0;
    for (int p = 0; p < NP; p++) pix[p] = 24'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cnt_bit", cnt_bit, 0);
    check("rst_cnt_pixel", cnt_pixel, 0);
    rst_n = 1'b1;

    run_single("fd_zeros");

    for (int p = 0; p < NP; p++)
      for (int b = 0; b < 24; b++) pix[p][23 - b] = b[0];
    run_single("fd_alternating");

    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < NP; p++) pix[p] = 24'($urandom);
      run_single("fd_random");
    end

    // start held high: two frames back-to-back with identical data
    for (int p = 0; p < NP; p++) pix[p] = 24'($urandom);
    push_frame(1'b0, 1'b1);
    push_frame(1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1;
    wait_fd("fd_chain_first");
    repeat (20) @(negedge clk);
    start = 1'b0;
    wait_fd("fd_chain_second");
    repeat (8) @(negedge clk);

    // start toggled while busy must not add or cut a frame
    for (int p = 0; p < NP; p++) pix[p] = 24'($urandom);
    push_frame(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < FRAME_LEN - 5; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_fd("fd_toggle");
    repeat (20) @(negedge clk);

    // reset in the high phase of pixel 1, bit 10
    for (int p = 0; p < NP; p++) pix[p] = 24'($urandom);
    pix[1][13] = 1'b1;
    push_frame(1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (cnt_pixel == 7'd1 && cnt_bit == 5'd10 && dout === 1'b1) found = 1'b1;
    end
    check("reset_target_reached", found, 1);
    #1;
    rst_n = 1'b0;
    exp_p.delete();
    exp_f.delete();
    #1;
    check("midrst_dout", dout, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt_bit", cnt_bit, 0);
    check("midrst_cnt_pixel", cnt_pixel, 0);
    check("midrst_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    stayed_low = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (dout !== 1'b0 || busy !== 1'b0) stayed_low = 1'b0;
    end
    check("post_reset_idle", stayed_low, 1);

    check("pulses_left", exp_p.size(), 0);
    check("frames_left", exp_f.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
